// File: rtl/scroll_engine_pkg.sv
// scroll_engine_pkg: shared console geometry, scroll request type and sequencer states
package scroll_engine_pkg;
  localparam int CONSOLE_COLUMNS = 80;
  localparam int CONSOLE_LINES = 24;
  typedef struct packed {
    logic       dir;
    logic [7:0] step;
    logic [7:0] top;
    logic [7:0] bottom;
  } Scrolling_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_SETUP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } ScrollState_t;
  function automatic logic [7:0] norm_step(input logic [7:0] s);
    return s == 8'd0 ? 8'd1 : s;
  endfunction
endpackage

// File: rtl/scroll_engine_row_copier.sv
// scroll_engine_row_copier: per-row column walker with a one-cycle read-to-write pipeline
module scroll_engine_row_copier #(
  parameter int COLS = 80,
  parameter int CELL_W = 16,
  parameter logic [CELL_W-1:0] BLANK = CELL_W'(16'h0020)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              run_i,
  input  logic              copy_i,
  input  logic [7:0]        dst_i,
  input  logic [CELL_W-1:0] rd_data_i,
  output logic [7:0]        col_o,
  output logic              col_last_o,
  output logic              wr_last_o,
  output logic              wr_en_o,
  output logic [7:0]        wr_row_o,
  output logic [7:0]        wr_col_o,
  output logic [CELL_W-1:0] wr_data_o
);
  localparam logic [7:0] LAST = 8'(COLS - 1);
  logic [7:0] col_q, col_d;
  logic       wr_en_q;
  logic [7:0] wr_row_q, wr_col_q;
  always_comb begin
    col_d = start_i ? 8'd0 : (run_i && col_q != LAST) ? col_q + 8'd1 : col_q;
  end
  // write stage trails the read address by one cycle to meet the RAM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_row_q <= '0;
      wr_col_q <= '0;
    end else begin
      col_q   <= col_d;
      wr_en_q <= run_i;
      if (run_i) begin
        wr_row_q <= dst_i;
        wr_col_q <= col_q;
      end
    end
  end
  assign col_o      = col_q;
  assign col_last_o = col_q == LAST;
  assign wr_last_o  = wr_en_q && wr_col_q == LAST;
  assign wr_en_o    = wr_en_q;
  assign wr_row_o   = wr_row_q;
  assign wr_col_o   = wr_col_q;
  assign wr_data_o  = wr_en_q ? (copy_i ? rd_data_i : BLANK) : '0;
endmodule

// File: rtl/scroll_engine.sv
// scroll_engine: walks a scroll region row by row, copying or blanking each row in the text RAM
module scroll_engine
  import scroll_engine_pkg::*;
#(
  parameter int COLS = CONSOLE_COLUMNS,
  parameter int LINES = CONSOLE_LINES,
  parameter int CELL_W = 16,
  parameter logic [CELL_W-1:0] BLANK = CELL_W'(16'h0020)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  Scrolling_t        req,
  input  logic              clear_all,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_row,
  output logic [7:0]        rd_col,
  input  logic [CELL_W-1:0] rd_data,
  output logic              wr_en,
  output logic [7:0]        wr_row,
  output logic [7:0]        wr_col,
  output logic [CELL_W-1:0] wr_data
);
  localparam logic [7:0] LAST_ROW = 8'(LINES - 1);
  localparam logic [7:0] N_LINES = 8'(LINES);
  ScrollState_t state_q, state_d;
  logic       dir_q, dir_d, copy_q, copy_d;
  logic [7:0] step_q, step_d, top_q, top_d, bot_q, bot_d;
  logic [7:0] dst_q, dst_d, src_q, src_d;
  logic       n_dir, last_row, col_last, wr_last;
  logic [7:0] n_step, n_top, n_bot;
  logic [8:0] up_src;
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    step_d   = step_q;
    top_d    = top_q;
    bot_d    = bot_q;
    dst_d    = dst_q;
    src_d    = src_q;
    copy_d   = copy_q;
    n_dir    = clear_all ? 1'b0 : req.dir;
    n_step   = clear_all ? N_LINES : norm_step(req.step);
    n_top    = clear_all ? 8'd0 : req.top;
    n_bot    = clear_all ? LAST_ROW : (req.bottom > LAST_ROW ? LAST_ROW : req.bottom);
    up_src   = {1'b0, dst_q} + {1'b0, step_q};
    last_row = dir_q ? dst_q == top_q : dst_q == bot_q;
    case (state_q)
      S_IDLE: if (clear_all || req_valid) begin
        dir_d   = n_dir;
        step_d  = n_step;
        top_d   = n_top;
        bot_d   = n_bot;
        dst_d   = n_dir ? n_bot : n_top;
        state_d = n_top > n_bot ? S_DONE : S_ROW_SETUP;
      end
      S_ROW_SETUP: begin
        // a source outside the region means the destination row is vacated
        src_d   = dir_q ? dst_q - step_q : up_src[7:0];
        copy_d  = dir_q ? {1'b0, dst_q} >= {1'b0, top_q} + {1'b0, step_q}
                        : up_src <= {1'b0, bot_q};
        state_d = S_STREAM;
      end
      S_STREAM: state_d = col_last ? S_DRAIN : S_STREAM;
      S_DRAIN: if (wr_last) begin
        state_d = last_row ? S_DONE : S_ROW_SETUP;
        dst_d   = last_row ? dst_q : dir_q ? dst_q - 8'd1 : dst_q + 8'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      copy_q  <= 1'b0;
      step_q  <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      copy_q  <= copy_d;
      step_q  <= step_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign rd_row    = src_q;
  scroll_engine_row_copier #(.COLS(COLS), .CELL_W(CELL_W), .BLANK(BLANK)) u_copier (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (state_q == S_ROW_SETUP),
    .run_i     (state_q == S_STREAM),
    .copy_i    (copy_q),
    .dst_i     (dst_q),
    .rd_data_i (rd_data),
    .col_o     (rd_col),
    .col_last_o(col_last),
    .wr_last_o (wr_last),
    .wr_en_o   (wr_en),
    .wr_row_o  (wr_row),
    .wr_col_o  (wr_col),
    .wr_data_o (wr_data)
  );
endmodule

// File: tb/tb_scroll_engine.sv
// tb_scroll_engine: text RAM model plus scroll-rule reference model checking every write and final buffer
module tb_scroll_engine;
  import scroll_engine_pkg::*;
  localparam int C = 80;
  localparam int L = 24;
  localparam logic [15:0] BL = 16'h0020;
  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [15:0] data;
  } wr_t;
  logic clk = 0, rst_n = 0, req_valid = 0, clear_all = 0, load = 0;
  Scrolling_t req = '0;
  logic req_ready, busy, done, wr_en;
  logic [7:0] rd_row, rd_col, wr_row, wr_col;
  logic [15:0] rd_data = '0, wr_data;
  logic [15:0] mem [L][C];
  logic [15:0] m [L][C];
  wr_t wq[$];
  wr_t plan[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  scroll_engine dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req(req), .clear_all(clear_all),
    .req_ready(req_ready), .busy(busy), .done(done), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );
  function automatic logic [15:0] init_cell(int r, int c);
    return {8'(r), 8'(c)};
  endfunction
  always @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < L; r++) for (int c = 0; c < C; c++) mem[r][c] <= init_cell(r, c);
    end else if (wr_en && wr_row < 8'(L) && wr_col < 8'(C)) mem[wr_row[4:0]][wr_col[6:0]] <= wr_data;
    rd_data <= (rd_row < 8'(L) && rd_col < 8'(C)) ? mem[rd_row[4:0]][rd_col[6:0]] : 16'hDEAD;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin : write_checker
    wr_t e;
    if (wr_en) begin
      if (wq.size() == 0) begin
        total++;
        $display("FAIL extra_write: row %0d col %0d data %h with nothing expected", wr_row, wr_col, wr_data);
      end else begin
        e = wq.pop_front();
        chk("write", {wr_row, wr_col, wr_data}, e);
      end
      chk("busy_during_write", busy, 1);
    end
  end
  task automatic reload();
    @(negedge clk) load = 1;
    @(negedge clk) load = 0;
    for (int r = 0; r < L; r++) for (int c = 0; c < C; c++) m[r][c] = init_cell(r, c);
  endtask
  task automatic plan_op(input logic clr, input logic dir, input int step, input int top,
                         input int bot, input int cut);
    int s, t, b, r, src;
    logic dr;
    plan.delete();
    dr = clr ? 1'b0 : dir;
    t  = clr ? 0 : top;
    s  = clr ? L : (step == 0 ? 1 : step);
    b  = clr ? L - 1 : (bot > L - 1 ? L - 1 : bot);
    for (int i = 0; i <= b - t; i++) begin
      r   = dr ? b - i : t + i;
      src = dr ? r - s : r + s;
      for (int c = 0; c < C; c++)
        plan.push_back(wr_t'{row: 8'(r), col: 8'(c), data: (src >= t && src <= b) ? m[src][c] : BL});
    end
    foreach (plan[k]) begin
      wq.push_back(plan[k]);
      if (cut < 0 || k < cut) m[plan[k].row][plan[k].col] = plan[k].data;
    end
  endtask
  task automatic accept();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      $display("FAIL accept_timeout: req_ready still 0 after %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(input string nm, input int exp_lat, input int exp_wr);
    int lat = 0, wc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({nm, "_busy_after_accept"}, busy, 1);
      if (wr_en) wc++;
    end while (!done && lat < 5000);
    chk({nm, "_done_latency"}, lat, exp_lat);
    chk({nm, "_write_count"}, wc, exp_wr);
  endtask
  task automatic compare_mem(input string nm);
    int bad;
    for (int r = 0; r < L; r++) begin
      bad = -1;
      for (int c = 0; c < C; c++) if (mem[r][c] !== m[r][c] && bad < 0) bad = c;
      if (bad < 0) bad = 0;
      chk($sformatf("%s_row%0d_col%0d", nm, r, bad), mem[r][bad], m[r][bad]);
    end
  endtask
  task automatic run(input string nm, input logic dir, input int step, input int top,
                     input int bot, input int exp_lat);
    plan_op(0, dir, step, top, bot, -1);
    req = '{dir: dir, step: 8'(step), top: 8'(top), bottom: 8'(bot)};
    req_valid = 1;
    accept();
    req_valid = 0;
    wait_done(nm, exp_lat, plan.size());
    compare_mem(nm);
    chk({nm, "_queue_drained"}, wq.size(), 0);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", {rd_row, rd_col, wr_row, wr_col}, 0);
    chk("rst_wr_data", wr_data, 0);
    rst_n = 1;
    reload();
    run("up_full", 0, 1, 0, 23, 1969);
    chk("pin_up_r0", mem[0][5], 16'h0105);
    chk("pin_up_r22", mem[22][79], 16'h174F);
    chk("pin_up_r23", mem[23][0], BL);
    chk("pin_model_r0", m[0][5], 16'h0105);
    reload();
    run("down_5_10", 1, 2, 5, 10, 493);
    chk("pin_dn_r7", mem[7][0], 16'h0500);
    chk("pin_dn_r10", mem[10][3], 16'h0803);
    chk("pin_dn_r5", mem[5][1], BL);
    chk("pin_dn_r6", mem[6][79], BL);
    chk("pin_dn_r4", mem[4][0], 16'h0400);
    chk("pin_dn_r11", mem[11][2], 16'h0B02);
    chk("pin_model_r7", m[7][0], 16'h0500);
    reload();
    run("up_bigstep", 0, 9, 3, 6, 329);
    chk("pin_big_r3", mem[3][0], BL);
    chk("pin_big_r6", mem[6][79], BL);
    chk("pin_big_r7", mem[7][0], 16'h0700);
    run("empty_step1", 0, 1, 8, 4, 1);
    run("empty_step0", 0, 0, 8, 4, 1);
    reload();
    run("step0", 0, 0, 2, 5, 329);
    chk("pin_s0_r2", mem[2][0], 16'h0300);
    chk("pin_s0_r4", mem[4][7], 16'h0507);
    chk("pin_s0_r5", mem[5][0], BL);
    reload();
    plan_op(1, 0, 0, 0, 0, -1);
    @(negedge clk);
    req = '{dir: 1'b1, step: 8'd3, top: 8'd2, bottom: 8'd20};
    clear_all = 1;
    req_valid = 1;
    accept();
    clear_all = 0;
    wait_done("clear", 1969, 1920);
    compare_mem("clear");
    chk("pin_clr_r0", mem[0][0], BL);
    chk("pin_clr_r23", mem[23][79], BL);
    plan_op(0, 1, 3, 2, 20, -1);
    accept();
    req_valid = 0;
    wait_done("after_clear", 1559, 1520);
    compare_mem("after_clear");
    chk("after_clear_queue_drained", wq.size(), 0);
    reload();
    plan_op(0, 0, 1, 0, 23, 2 * C + 41);
    req = '{dir: 1'b0, step: 8'd1, top: 8'd0, bottom: 8'd23};
    req_valid = 1;
    accept();
    req_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(wr_en && wr_row == 8'd2 && wr_col == 8'd40) && n < 1000);
    chk("reset_point_reached", {wr_en, wr_row, wr_col}, {1'b1, 8'd2, 8'd40});
    rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_done", done, 0);
    wq.delete();
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_writes", wr_en, 0);
    compare_mem("midrst");
    chk("pin_rst_r1", mem[1][0], 16'h0200);
    chk("pin_rst_r2c40", mem[2][40], 16'h0328);
    chk("pin_rst_r2c41", mem[2][41], 16'h0229);
    chk("pin_rst_r3", mem[3][0], 16'h0300);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
